// File: rtl/upload_packer_pkg.sv
// Shared framing constants, handler source codes and the packer state encoding.
// UPLOAD_CHECKSUM_EN adds the S_CSUM trailer state.
package upload_packer_pkg;

  localparam logic [7:0] FRAME_SYNC0 = 8'hAA;
  localparam logic [7:0] FRAME_SYNC1 = 8'h44;

  localparam logic [7:0] CMD_I2C_CONFIG = 8'h04;
  localparam logic [7:0] CMD_I2C_WRITE  = 8'h05;
  localparam logic [7:0] CMD_I2C_READ   = 8'h06;

  localparam int unsigned HDR_LEN = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_HDR,
    S_PAYLOAD
`ifdef UPLOAD_CHECKSUM_EN
    ,
    S_CSUM
`endif
  } state_e;

  // Header byte at position idx of: sync0, sync1, src, len_hi, len_lo.
  function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                          input logic [7:0]  src,
                                          input logic [15:0] len);
    case (idx)
      3'd0:    return FRAME_SYNC0;
      3'd1:    return FRAME_SYNC1;
      3'd2:    return src;
      3'd3:    return len[15:8];
      default: return len[7:0];
    endcase
  endfunction

endpackage

// File: rtl/upload_payload_ram.sv
// Simple dual-port payload buffer: one write port, one registered read port.
// Contents are not reset; only bytes below the live count are ever read out.
module upload_payload_ram
  import upload_packer_pkg::*;
#(
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/upload_packer.sv
// Buffers the handler upload byte stream and emits framed packets
// (AA 44 src len_hi len_lo payload [csum]); UPLOAD_CHECKSUM_EN enables the csum trailer.
module upload_packer
  import upload_packer_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD   = 256,
  parameter int unsigned FLUSH_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upload_req,
  input  logic       upload_valid,
  input  logic [7:0] upload_data,
  input  logic [7:0] upload_source,
  output logic       upload_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int unsigned AW    = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned IW    = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [15:0]   MAX_CNT = 16'(MAX_PAYLOAD);
  localparam logic [IW-1:0] TMO_CNT = IW'(FLUSH_TIMEOUT);

  state_e         state_q, state_d;
  logic [7:0]     src_q, src_d;
  logic [15:0]    count_q, count_d;
  logic [15:0]    idx_q, idx_d;
  logic [IW-1:0]  idle_q, idle_d;
  logic           carry_v_q, carry_v_d;
  logic [7:0]     carry_data_q, carry_data_d;
  logic [7:0]     carry_src_q, carry_src_d;
  logic           ready_q, ready_d;
`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0]     psum_q, psum_d;
`endif

  logic           accept;
  logic           frame_done;
  logic           ram_we;
  logic [AW-1:0]  ram_waddr;
  logic [7:0]     ram_wdata;
  logic [AW-1:0]  ram_raddr;
  logic [7:0]     ram_rdata;

  // upload_req carries no framing meaning here.
  logic unused_req;
  assign unused_req = upload_req;

  assign accept       = upload_valid && ready_q;
  assign upload_ready = ready_q;

  upload_payload_ram #(
    .AW   (AW),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    count_d      = count_q;
    idx_d        = idx_q;
    idle_d       = idle_q;
    carry_v_d    = carry_v_q;
    carry_data_d = carry_data_q;
    carry_src_d  = carry_src_q;
`ifdef UPLOAD_CHECKSUM_EN
    psum_d       = psum_q;
`endif
    frame_done   = 1'b0;
    ram_we       = 1'b0;
    ram_waddr    = '0;
    ram_wdata    = upload_data;
    ram_raddr    = '0;
    tx_valid     = 1'b0;
    tx_data      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          ram_we  = 1'b1;
          src_d   = upload_source;
          count_d = 16'd1;
          idle_d  = '0;
`ifdef UPLOAD_CHECKSUM_EN
          psum_d  = upload_data;
`endif
          state_d = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (accept && (upload_source != src_q)) begin
          carry_v_d    = 1'b1;
          carry_data_d = upload_data;
          carry_src_d  = upload_source;
          idx_d        = '0;
          state_d      = S_HDR;
        end else if (accept) begin
          ram_we    = 1'b1;
          ram_waddr = AW'(count_q);
          count_d   = count_q + 16'd1;
          idle_d    = '0;
`ifdef UPLOAD_CHECKSUM_EN
          psum_d    = psum_q + upload_data;
`endif
        end else if ((idle_q == TMO_CNT) || (count_q == MAX_CNT)) begin
          idx_d   = '0;
          state_d = S_HDR;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end

      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte(idx_q[2:0], src_q, count_q);
        if (tx_ready) begin
          if (idx_q == 16'(HDR_LEN - 1)) begin
            idx_d   = '0;
            state_d = S_PAYLOAD;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end

      S_PAYLOAD: begin
        // Read address runs one byte ahead on advance so rdata is ready the next cycle.
        tx_valid  = 1'b1;
        tx_data   = ram_rdata;
        ram_raddr = AW'(idx_q);
        if (tx_ready) begin
          ram_raddr = AW'(idx_q + 16'd1);
          if (idx_q == (count_q - 16'd1)) begin
`ifdef UPLOAD_CHECKSUM_EN
            state_d = S_CSUM;
`else
            frame_done = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end

`ifdef UPLOAD_CHECKSUM_EN
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = src_q + count_q[15:8] + count_q[7:0] + psum_q;
        if (tx_ready) begin
          frame_done = 1'b1;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // A held carry byte opens the next packet directly as buf[0].
    if (frame_done) begin
      if (carry_v_q) begin
        ram_we    = 1'b1;
        ram_waddr = '0;
        ram_wdata = carry_data_q;
        src_d     = carry_src_q;
        count_d   = 16'd1;
        idle_d    = '0;
        carry_v_d = 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
        psum_d    = carry_data_q;
`endif
        state_d   = S_COLLECT;
      end else begin
        count_d = '0;
        state_d = S_IDLE;
      end
    end

    ready_d = (state_d == S_IDLE) || ((state_d == S_COLLECT) && (count_d < MAX_CNT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      idle_q       <= '0;
      carry_v_q    <= 1'b0;
      carry_data_q <= '0;
      carry_src_q  <= '0;
      ready_q      <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
      psum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      idle_q       <= idle_d;
      carry_v_q    <= carry_v_d;
      carry_data_q <= carry_data_d;
      carry_src_q  <= carry_src_d;
      ready_q      <= ready_d;
`ifdef UPLOAD_CHECKSUM_EN
      psum_q       <= psum_d;
`endif
    end
  end

endmodule

// File: tb/tb_upload_packer.sv
// Directed bench for upload_packer (MAX_PAYLOAD=4, FLUSH_TIMEOUT=16); the expected
// csum trailer follows UPLOAD_CHECKSUM_EN.
module tb_upload_packer;
  import upload_packer_pkg::*;

  localparam int unsigned MAXP = 4;
  localparam int unsigned TMO  = 16;
`ifdef UPLOAD_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef logic [7:0] bq_t [$];
  typedef struct {
    logic [7:0] src;
    int         n;
    logic [7:0] pay [4];
    logic [7:0] csum;
    bit         stall;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       upload_req;
  logic       upload_valid;
  logic [7:0] upload_data;
  logic [7:0] upload_source;
  logic       upload_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_acc = 0;
  bit mon_en        = 1'b0;
  bit stall_mode    = 1'b0;
  bit stall_pending = 1'b0;
  logic [7:0] stall_data;
  logic [7:0] rx_q [$];
  int         rx_cyc [$];

  upload_packer #(
    .MAX_PAYLOAD  (MAXP),
    .FLUSH_TIMEOUT(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .upload_req   (upload_req),
    .upload_valid (upload_valid),
    .upload_data  (upload_data),
    .upload_source(upload_source),
    .upload_ready (upload_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Outputs and inputs are stable at the falling edge; handshakes seen here
  // complete at the following rising edge (cyc + 1).
  always @(negedge clk) begin
    if (upload_valid && upload_ready) last_acc = cyc + 1;
    if (mon_en) begin
      if (stall_pending) begin
        check("stall_valid", int'(tx_valid), 1);
        check("stall_data", int'(tx_data), int'(stall_data));
      end
      stall_pending = tx_valid && !tx_ready;
      stall_data    = tx_data;
      if (tx_valid && tx_ready) begin
        rx_q.push_back(tx_data);
        rx_cyc.push_back(cyc);
      end
    end
  end

  initial begin : ready_drv
    int ph;
    ph = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode) begin
        tx_ready = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        tx_ready = 1'b1;
        ph = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [7:0] s);
    int n;
    n = 0;
    upload_valid  = 1'b1;
    upload_data   = d;
    upload_source = s;
    @(negedge clk);
    while (!upload_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_ready_timeout", 0, 1);
    tick();
    upload_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int t;
    t = 0;
    while (rx_q.size() < n && t < 400) begin
      tick();
      t++;
    end
    if (rx_q.size() < n) check("rx_timeout", rx_q.size(), n);
    repeat (4) tick();
  endtask

  function automatic bq_t make_frame(input logic [7:0] src, input int n,
                                     input logic [7:0] pay [4], input logic [7:0] csum);
    bq_t f;
    f.push_back(8'hAA);
    f.push_back(8'h44);
    f.push_back(src);
    f.push_back(8'h00);
    f.push_back(8'(n));
    for (int i = 0; i < n; i++) f.push_back(pay[i]);
    if (CSUM_EN) f.push_back(csum);
    return f;
  endfunction

  task automatic compare_rx(input string tag, input bq_t exp);
    check({tag, "_len"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s_b%0d", tag, i), (i < rx_q.size()) ? int'(rx_q[i]) : -1, int'(exp[i]));
  endtask

  initial begin : main
    vec_t vecs [5];
    bq_t  exp;
    logic [7:0] p1 [4];
    logic [7:0] p2 [4];
    int t;

    // Hand-computed csum = src + len_hi + len_lo + payload (mod 256).
    vecs[0] = '{CMD_I2C_READ,   3, '{8'h11, 8'h22, 8'h33, 8'h00}, 8'h6F, 1'b0};
    vecs[1] = '{CMD_I2C_WRITE,  1, '{8'hB0, 8'h00, 8'h00, 8'h00}, 8'hB6, 1'b0};
    vecs[2] = '{CMD_I2C_CONFIG, 4, '{8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'h04, 1'b0};
    vecs[3] = '{CMD_I2C_READ,   1, '{8'h42, 8'h00, 8'h00, 8'h00}, 8'h49, 1'b0};
    vecs[4] = '{CMD_I2C_READ,   3, '{8'h11, 8'h22, 8'h33, 8'h00}, 8'h6F, 1'b1};

    rst           = 1'b1;
    upload_req    = 1'b0;
    upload_valid  = 1'b0;
    upload_data   = 8'h00;
    upload_source = 8'h00;
    repeat (3) tick();
    check("rst_upload_ready", int'(upload_ready), 0);
    check("rst_tx_valid", int'(tx_valid), 0);
    check("rst_tx_data", int'(tx_data), 0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", int'(upload_ready), 1);
    mon_en = 1'b1;

    foreach (vecs[i]) begin
      rx_q.delete();
      rx_cyc.delete();
      stall_mode = vecs[i].stall;
      upload_req = 1'b1;
      for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].pay[j], vecs[i].src);
      upload_req = 1'b0;
      check($sformatf("v%0d_ready_after_last", i), int'(upload_ready),
            (vecs[i].n < int'(MAXP)) ? 1 : 0);
      exp = make_frame(vecs[i].src, vecs[i].n, vecs[i].pay, vecs[i].csum);
      wait_rx(exp.size());
      compare_rx($sformatf("v%0d", i), exp);
      if (!vecs[i].stall && rx_cyc.size() == exp.size()) begin
        check($sformatf("v%0d_start_cycle", i), rx_cyc[0],
              last_acc + ((vecs[i].n < int'(MAXP)) ? int'(TMO) + 1 : 1));
        check($sformatf("v%0d_span", i), rx_cyc[$] - rx_cyc[0], exp.size() - 1);
      end
      check($sformatf("v%0d_idle_valid", i), int'(tx_valid), 0);
      stall_mode = 1'b0;
      repeat (2) tick();
    end

    // Full buffer splits six bytes into 4 + 2.
    rx_q.delete();
    rx_cyc.delete();
    for (int j = 1; j <= 6; j++) begin
      send_byte(8'(j), CMD_I2C_READ);
      if (j == 4) check("full_ready_drop", int'(upload_ready), 0);
    end
    p1 = '{8'h01, 8'h02, 8'h03, 8'h04};
    p2 = '{8'h05, 8'h06, 8'h00, 8'h00};
    exp = {make_frame(CMD_I2C_READ, 4, p1, 8'h14), make_frame(CMD_I2C_READ, 2, p2, 8'h13)};
    wait_rx(exp.size());
    compare_rx("full", exp);

    // Source change closes the first packet and carries the new byte.
    rx_q.delete();
    rx_cyc.delete();
    send_byte(8'hA0, CMD_I2C_READ);
    send_byte(8'hB0, CMD_I2C_WRITE);
    check("srcchg_ready", int'(upload_ready), 0);
    p1 = '{8'hA0, 8'h00, 8'h00, 8'h00};
    p2 = '{8'hB0, 8'h00, 8'h00, 8'h00};
    exp = {make_frame(CMD_I2C_READ, 1, p1, 8'hA7), make_frame(CMD_I2C_WRITE, 1, p2, 8'hB6)};
    wait_rx(exp.size());
    compare_rx("srcchg", exp);

    // Reset during payload transmission.
    rx_q.delete();
    rx_cyc.delete();
    send_byte(8'h11, CMD_I2C_READ);
    send_byte(8'h22, CMD_I2C_READ);
    send_byte(8'h33, CMD_I2C_READ);
    t = 0;
    while (rx_q.size() < 6 && t < 200) begin
      tick();
      t++;
    end
    check("rstmid_reached_payload", int'(rx_q.size() >= 6), 1);
    rst = 1'b1;
    #1;
    check("rstmid_tx_valid", int'(tx_valid), 0);
    tick();
    rst = 1'b0;
    tick();
    check("rstmid_ready", int'(upload_ready), 1);
    rx_q.delete();
    rx_cyc.delete();
    send_byte(8'h42, CMD_I2C_READ);
    p1 = '{8'h42, 8'h00, 8'h00, 8'h00};
    exp = make_frame(CMD_I2C_READ, 1, p1, 8'h49);
    wait_rx(exp.size());
    compare_rx("rstmid", exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
